// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between the fetch stage (reads) and the
// program loader (writes). Fetch has priority in RUN; the loader owns the port in LOAD.
module imem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WAIT   = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_gnt,
    input  logic                  load_mode,
    output logic                  busy_load,
    output logic [CNT_WIDTH-1:0]  ld_count,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_FLUSH
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                forced;

    // Byte addresses are halved to word addresses, so bit 0 never reaches the macro.
    logic unused_addr_lsb;
    assign unused_addr_lsb = fetch_addr[0] ^ ld_addr[0];

    assign forced     = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign fetch_data = mem_rdata;

    // Grant arbitration: nothing is granted during reset or FLUSH.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (forced && ld_req) begin
                        ld_gnt = 1'b1;
                    end else if (fetch_req) begin
                        fetch_gnt = 1'b1;
                    end else begin
                        ld_gnt = ld_req;
                    end
                end
                ST_LOAD: ld_gnt = ld_req;
                default: ;
            endcase
        end
    end

    // Memory port mux driven by whichever requester holds the grant.
    always_comb begin
        mem_en    = fetch_gnt | ld_gnt;
        mem_we    = ld_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_addr  = {1'b0, ld_addr[ADDR_WIDTH-1:1]};
            mem_wdata = ld_wdata;
        end else if (fetch_gnt) begin
            mem_addr  = {1'b0, fetch_addr[ADDR_WIDTH-1:1]};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:   if (load_mode) next_state = ST_LOAD;
            ST_LOAD:  if (!load_mode) next_state = ST_FLUSH;
            ST_FLUSH: next_state = load_mode ? ST_LOAD : ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            fetch_valid <= 1'b0;
            ld_count    <= '0;
            busy_load   <= 1'b0;
        end else begin
            state       <= next_state;
            fetch_valid <= fetch_gnt;
            busy_load   <= (next_state != ST_RUN);

            // Starvation counter only runs while staying in RUN; it saturates via the forced grant.
            if (state == ST_RUN && next_state == ST_RUN) begin
                if (ld_gnt || !ld_req) begin
                    wait_cnt <= '0;
                end else if (!forced) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end

            if (next_state == ST_LOAD && state != ST_LOAD) begin
                ld_count <= '0;
            end else if (state == ST_LOAD && ld_gnt) begin
                ld_count <= ld_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed-vector bench for imem_port_arbiter with a small registered-read memory model.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_gnt;
    logic        load_mode;
    logic        busy_load;
    logic [15:0] ld_count;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem [0:255];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_WAIT(8), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .load_mode(load_mode), .busy_load(busy_load), .ld_count(ld_count),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Registered-read single-port memory
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        mem_rdata  = '0;
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_req     = 1'b0;
        ld_addr    = '0;
        ld_wdata   = '0;
        load_mode  = 1'b0;
        tick();
        tick();

        // Requests during reset must not be granted
        fetch_req = 1'b1;
        ld_req    = 1'b1;
        #1;
        check("rst_fetch_gnt", fetch_gnt, 0);
        check("rst_ld_gnt", ld_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        tick();
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_busy", busy_load, 0);
        check("rst_ld_count", ld_count, 0);

        // First fetch after reset
        rst        = 1'b0;
        ld_req     = 1'b0;
        fetch_addr = 16'h0004;
        #1;
        check("f0_gnt", fetch_gnt, 1);
        check("f0_mem_addr", mem_addr, 16'h0002);
        check("f0_mem_we", mem_we, 0);
        tick();
        check("f0_valid", fetch_valid, 1);
        check("f0_data", fetch_data, 16'hA002);

        // Starvation: loader forced a grant on the 9th cycle, twice in a row
        fetch_addr = 16'h0010;
        ld_req     = 1'b1;
        ld_addr    = 16'h0020;
        ld_wdata   = 16'h1234;
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 9; c++) begin
                #1;
                check("st_ld_gnt", ld_gnt, (c == 9) ? 1 : 0);
                check("st_fetch_gnt", fetch_gnt, (c == 9) ? 0 : 1);
                if (c == 9) begin
                    check("st_mem_addr", mem_addr, (r == 0) ? 16'h0010 : 16'h0011);
                    check("st_mem_wdata", mem_wdata, (r == 0) ? 16'h1234 : 16'h5678);
                end
                tick();
                if (c == 9) check("st_valid_after_forced", fetch_valid, 0);
            end
            ld_addr  = 16'h0022;
            ld_wdata = 16'h5678;
        end
        ld_req = 1'b0;

        // Fetch granted in the last RUN cycle as load_mode rises
        fetch_addr = 16'h0004;
        load_mode  = 1'b1;
        #1;
        check("entry_fetch_gnt", fetch_gnt, 1);
        tick();
        check("load_valid", fetch_valid, 1);
        check("load_data", fetch_data, 16'hA002);
        check("load_busy", busy_load, 1);
        check("load_cnt0", ld_count, 0);

        // Five writes in LOAD with fetch still requesting
        ld_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ld_addr  = 16'(2 * i);
            ld_wdata = 16'hC000 + 16'(i);
            #1;
            check("load_ld_gnt", ld_gnt, 1);
            check("load_fetch_gnt", fetch_gnt, 0);
            check("load_we", mem_we, 1);
            check("load_mem_addr", mem_addr, 32'(i));
            tick();
        end
        check("load_cnt5", ld_count, 5);

        ld_req = 1'b0;
        #1;
        check("load_idle_en", mem_en, 0);
        check("load_idle_fetch", fetch_gnt, 0);
        tick();

        // Exit with a write in the same cycle load_mode drops
        load_mode = 1'b0;
        ld_req    = 1'b1;
        ld_addr   = 16'h000A;
        ld_wdata  = 16'hC005;
        #1;
        check("exit_ld_gnt", ld_gnt, 1);
        tick();
        ld_req = 1'b0;
        fetch_addr = 16'h0006;
        #1;
        check("flush_busy", busy_load, 1);
        check("flush_cnt", ld_count, 6);
        check("flush_fetch_gnt", fetch_gnt, 0);
        check("flush_mem_en", mem_en, 0);
        tick();
        check("run_busy", busy_load, 0);
        check("run_fetch_gnt", fetch_gnt, 1);
        tick();
        check("run_valid", fetch_valid, 1);
        check("run_data", fetch_data, 16'hC003);
        check("run_cnt_hold", ld_count, 6);

        // Reset during LOAD after three writes
        fetch_req = 1'b0;
        load_mode = 1'b1;
        tick();
        ld_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_addr  = 16'h0040 + 16'(2 * i);
            ld_wdata = 16'hD000 + 16'(i);
            tick();
        end
        check("mid_cnt3", ld_count, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_ld_gnt", ld_gnt, 0);
        check("mid_rst_we", mem_we, 0);
        tick();
        check("mid_rst_busy", busy_load, 0);
        check("mid_rst_cnt", ld_count, 0);
        rst        = 1'b0;
        load_mode  = 1'b0;
        ld_req     = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0040;
        #1;
        check("post_rst_fetch_gnt", fetch_gnt, 1);
        check("post_rst_we", mem_we, 0);
        tick();
        check("post_rst_data", fetch_data, 16'hD000);
        fetch_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
